ravens_spike_byte_tx: RTL and testbench

- Downstream neighbour of the DVS-event-to-RAVENS-spike converter.
- Accepts 32-bit RAVENS spike packets on a valid/ready input and buffers them in a small FIFO.
- Serializes each packet MSB-first into 4 bytes on a byte-wide valid/ready output feeding the RAVENS link/UART bridge.
- Drops packets on overflow, flags the drop, and never stalls the combinational converter path.

---
 rtl/dvs_ravens_pkg.sv | 14 +
 rtl/ravens_pkt_fifo.sv | 58 +++++
 rtl/ravens_spike_byte_tx.sv | 144 ++++++++++++++
 tb/tb_ravens_spike_byte_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dvs_ravens_pkg.sv
// Shared definitions for the DVS-to-RAVENS datapath.
// Provides the RAVENS spike packet width, the number of bytes per packet on
// the byte link, and the byte-serializer state encoding.
package dvs_ravens_pkg;

  localparam int unsigned RAVENS_PKT_BITS = 32;
  localparam int unsigned RAVENS_TX_BYTES = RAVENS_PKT_BITS / 8;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

endpackage

// File: rtl/ravens_pkt_fifo.sv
// Synchronous circular-buffer FIFO for RAVENS spike packets.
// Pointers carry an extra wrap bit so full and empty can be told apart
// without a separate counter.
// Ports:
//   clk, rst            clock, async active-high reset (clears pointers)
//   push, push_data     write request and data (ignored when full)
//   pop, pop_data       read request (ignored when empty); pop_data is the head
//   full, empty, count  occupancy status decoded from the pointer registers
module ravens_pkt_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same index with opposite wrap bits means the writer lapped the reader.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Storage; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ravens_spike_byte_tx.sv
// RAVENS spike packet byte transmitter.
// Buffers 32-bit spike packets from the converter in a small FIFO and
// serializes each one MSB-first as bytes onto a valid/ready link. Packets
// offered while the FIFO is full are dropped and flagged; the input side
// never waits on the output side.
// Optional build macro: RAVENS_TX_DROP_CNT_EN adds a saturating 16-bit
// drop_count output; overflow then reflects drop_count != 0.
// Ports:
//   clk, rst                     clock, async active-high reset
//   spike_in, spike_in_valid     packet input
//   spike_in_ready               FIFO not full
//   byte_out, byte_out_valid     serialized byte output
//   byte_out_ready               sink accepts byte_out
//   fifo_count                   packets buffered (excludes shift register)
//   overflow                     sticky: a packet has been dropped
//   drop_count                   dropped packets, saturating (macro only)
module ravens_spike_byte_tx
  import dvs_ravens_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BYTE_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RAVENS_PKT_BITS-1:0]   spike_in,
  input  logic                         spike_in_valid,
  output logic                         spike_in_ready,
  output logic [BYTE_BITS-1:0]         byte_out,
  output logic                         byte_out_valid,
  input  logic                         byte_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
`ifdef RAVENS_TX_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_count
`endif
);

  localparam int unsigned NUM_BYTES = RAVENS_PKT_BITS / BYTE_BITS;
  localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  tx_state_t                  state;
  logic [RAVENS_PKT_BITS-1:0] shreg;
  logic [IDX_W-1:0]           byte_idx;
  logic [RAVENS_PKT_BITS-1:0] fifo_head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push_c;
  logic                       pop_c;
  logic                       drop_c;
  logic                       last_hs_c;

  // Input handshake depends only on registered FIFO state
  assign spike_in_ready = !fifo_full;
  assign push_c         = spike_in_valid && !fifo_full;
  assign drop_c         = spike_in_valid && fifo_full;

  // Pop on entry from IDLE, or back-to-back on the final byte handshake
  assign last_hs_c = (state == TX_SEND) && byte_out_ready && (byte_idx == LAST_IDX);
  assign pop_c     = !fifo_empty && ((state == TX_IDLE) || last_hs_c);

  assign byte_out = shreg[RAVENS_PKT_BITS-1 -: BYTE_BITS];

  ravens_pkt_fifo #(
    .WIDTH (RAVENS_PKT_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (spike_in),
    .pop       (pop_c),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Serializer FSM with shift register and registered valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= TX_IDLE;
      shreg          <= '0;
      byte_idx       <= '0;
      byte_out_valid <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            shreg          <= fifo_head;
            byte_idx       <= '0;
            byte_out_valid <= 1'b1;
            state          <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (byte_out_ready) begin
            if (byte_idx == LAST_IDX) begin
              if (!fifo_empty) begin
                shreg    <= fifo_head;
                byte_idx <= '0;
              end else begin
                shreg          <= shreg << BYTE_BITS;
                byte_out_valid <= 1'b0;
                state          <= TX_IDLE;
              end
            end else begin
              shreg    <= shreg << BYTE_BITS;
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state          <= TX_IDLE;
          byte_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAVENS_TX_DROP_CNT_EN
  // Saturating drop counter; overflow is derived from it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop_c && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  assign overflow = (drop_count != 16'd0);
`else
  // Sticky drop flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ravens_spike_byte_tx.sv
// Scoreboard bench for ravens_spike_byte_tx: stimulus pushes expected bytes
// into a queue, a negedge monitor pops and compares on every byte handshake.
module tb_ravens_spike_byte_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] spike_in;
  logic        spike_in_valid;
  logic        spike_in_ready;
  logic [7:0]  byte_out;
  logic        byte_out_valid;
  logic        byte_out_ready;
  logic [3:0]  fifo_count;
  logic        overflow;
`ifdef RAVENS_TX_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ravens_spike_byte_tx #(
    .FIFO_DEPTH (8),
    .BYTE_BITS  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .spike_in       (spike_in),
    .spike_in_valid (spike_in_valid),
    .spike_in_ready (spike_in_ready),
    .byte_out       (byte_out),
    .byte_out_valid (byte_out_valid),
    .byte_out_ready (byte_out_ready),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
`ifdef RAVENS_TX_DROP_CNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  // Monitor: every byte accepted by the sink must match the queue head
  always @(negedge clk) begin
    if (!rst && byte_out_valid && byte_out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte got %02h expected none", byte_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (byte_out !== e) begin
          errors++;
          $display("FAIL byte_stream got %02h expected %02h", byte_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_pkt(input logic [31:0] p);
    exp_q.push_back(p[31:24]);
    exp_q.push_back(p[23:16]);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[7:0]);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || byte_out_valid); i++) tick();
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_valid_low"}, 32'(byte_out_valid), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !byte_out_valid; i++) tick();
    chk({name, "_valid_seen"}, 32'(byte_out_valid), 32'd1);
  endtask

  initial begin
    int n;
    rst            = 1'b1;
    spike_in       = '0;
    spike_in_valid = 1'b0;
    byte_out_ready = 1'b1;
    #1;
    chk("reset_valid", 32'(byte_out_valid), 32'd0);
    chk("reset_byte", 32'(byte_out), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_ready", 32'(spike_in_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single packet: latency and byte order
    exp_pkt(32'h00000B40);
    spike_in = 32'h00000B40; spike_in_valid = 1'b1;
    tick();
    spike_in_valid = 1'b0;
    chk("t1_valid_n1", 32'(byte_out_valid), 32'd0);
    tick();
    chk("t1_valid_n2", 32'(byte_out_valid), 32'd1);
    chk("t1_first_byte", 32'(byte_out), 32'h00);
    drain("t1");

    // Back-to-back packets with no bubble
    exp_pkt(32'h00000B40);
    exp_pkt(32'h00001FE0);
    spike_in = 32'h00000B40; spike_in_valid = 1'b1;
    tick();
    spike_in = 32'h00001FE0;
    tick();
    spike_in_valid = 1'b0;
    n = 0;
    while (byte_out_valid && n < 20) begin
      n++;
      tick();
    end
    chk("t2_valid_run", 32'(n), 32'd8);
    drain("t2");

    // Stall while byte 2 is presented
    exp_pkt(32'h00000B40);
    spike_in = 32'h00000B40; spike_in_valid = 1'b1;
    tick();
    spike_in_valid = 1'b0;
    wait_valid("t3");
    tick();
    tick();
    byte_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_byte", 32'(byte_out), 32'h0B);
      chk("t3_hold_valid", 32'(byte_out_valid), 32'd1);
      tick();
    end
    byte_out_ready = 1'b1;
    drain("t3");

    // Overflow: 10 pushes with sink stalled
    byte_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) chk("t4_ready_before_9th", 32'(spike_in_ready), 32'd1);
      if (i == 9) begin
        chk("t4_ready_full", 32'(spike_in_ready), 32'd0);
        chk("t4_count_full", 32'(fifo_count), 32'd8);
        chk("t4_overflow_before", 32'(overflow), 32'd0);
      end
      spike_in = 32'hA1B2C300 + 32'(i); spike_in_valid = 1'b1;
      tick();
    end
    spike_in_valid = 1'b0;
    chk("t4_overflow_after", 32'(overflow), 32'd1);
`ifdef RAVENS_TX_DROP_CNT_EN
    chk("t4_drop_count", 32'(drop_count), 32'd1);
`endif
    chk("t4_shreg_byte", 32'(byte_out), 32'hA1);
    chk("t4_shreg_valid", 32'(byte_out_valid), 32'd1);
    for (int i = 0; i < 9; i++) exp_pkt(32'hA1B2C300 + 32'(i));
    byte_out_ready = 1'b1;
    drain("t4");
    chk("t4_count_drained", 32'(fifo_count), 32'd0);
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a packet, with another buffered
    exp_q.push_back(8'hDE);
    exp_q.push_back(8'hAD);
    spike_in = 32'hDEADBEEF; spike_in_valid = 1'b1;
    tick();
    spike_in = 32'h11223344;
    tick();
    spike_in_valid = 1'b0;
    chk("t5_first_byte", 32'(byte_out), 32'hDE);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(byte_out_valid), 32'd0);
    chk("t5_rst_count", 32'(fifo_count), 32'd0);
    chk("t5_rst_overflow", 32'(overflow), 32'd0);
`ifdef RAVENS_TX_DROP_CNT_EN
    chk("t5_rst_drop_count", 32'(drop_count), 32'd0);
`endif
    chk("t5_bytes_consumed", 32'(exp_q.size()), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    exp_pkt(32'h00000020);
    spike_in = 32'h00000020; spike_in_valid = 1'b1;
    tick();
    spike_in_valid = 1'b0;
    drain("t5");

    // Simultaneous push and pop at count 4, across the pointer wrap
    byte_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spike_in = 32'h5A000000 + 32'(i << 8) + 32'(i); spike_in_valid = 1'b1;
      tick();
    end
    spike_in_valid = 1'b0;
    chk("t6_count_start", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 5; i++) exp_pkt(32'h5A000000 + 32'(i << 8) + 32'(i));
    byte_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      tick();
      tick();
      exp_pkt(32'hC0DE0000 + 32'(k * 17));
      spike_in = 32'hC0DE0000 + 32'(k * 17); spike_in_valid = 1'b1;
      tick();
      spike_in_valid = 1'b0;
      chk("t6_count_steady", 32'(fifo_count), 32'd4);
    end
    drain("t6");
    chk("t6_count_end", 32'(fifo_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound in case a loop ever stalls
  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
